load_store_unit: RTL and testbench

Core-side load/store stage that turns execute-stage memory instructions into word-granular transactions on `LargeMemory`'s write (`in_*`) and read (`out_*`) handshakes. It sits directly upstream of `LargeMemory` and downstream of execute. It handles sub-word access by sign/zero extension on loads and read-modify-write on stores. It reports misalignment, illegal width and memory `addr_error` as a single error flag to writeback.

---
 rtl/felis_lsu_pkg.sv | 22 ++
 rtl/lsu_lane_align.sv | 45 ++++
 rtl/load_store_unit.sv | 150 +++++++++++++++
 tb/tb_load_store_unit.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/felis_lsu_pkg.sv
// Shared types and constants for the load/store unit: width codes, FSM states
// and the word-alignment helper used for every memory address.
package felis_lsu_pkg;
  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } lsu_state_t;

  function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: load extraction/extension, store byte/half merge,
// and the alignment/width legality checks for one access.
module lsu_lane_align
  import felis_lsu_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_i,
  input  logic [XLEN-1:0] mem_word_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] load_value_o,
  output logic [XLEN-1:0] merged_word_o,
  output logic            misaligned_o,
  output logic            illegal_o
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = mem_word_i[{addr_i, 3'b000} +: 8];
    half_sel = addr_i[1] ? mem_word_i[31:16] : mem_word_i[15:0];

    load_value_o = '0;
    case (funct3_i)
      F3_B:    load_value_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_value_o = {24'h0, byte_sel};
      F3_H:    load_value_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_value_o = {16'h0, half_sel};
      F3_W:    load_value_o = mem_word_i;
      default: load_value_o = '0;
    endcase

    // Only the addressed lane changes; the rest of the word is written back as read.
    merged_word_o = mem_word_i;
    if (funct3_i[1:0] == 2'b00)
      merged_word_o[{addr_i, 3'b000} +: 8] = wdata_i[7:0];
    else if (funct3_i[1:0] == 2'b01)
      merged_word_o[{addr_i[1], 4'b0000} +: 16] = wdata_i[15:0];
    else
      merged_word_o = wdata_i;

    misaligned_o = ((funct3_i == F3_H || funct3_i == F3_HU) && addr_i[0]) ||
                   (funct3_i == F3_W && addr_i != 2'b00);
    illegal_o    = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11);
  end
endmodule

// File: rtl/load_store_unit.sv
// Load/store stage: one access at a time, read-modify-write for sub-word stores,
// all faults folded into resp_error. Handshakes: a transfer happens on a rising
// clk edge where valid and ready are both high; valid, once raised, holds its payload stable until that edge.
module load_store_unit
  import felis_lsu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_error,
  output logic [XLEN-1:0] mem_in_addr,
  output logic [XLEN-1:0] mem_in_data,
  output logic            mem_in_valid,
  input  logic            mem_in_ready,
  output logic [XLEN-1:0] mem_out_addr,
  output logic            mem_out_valid,
  input  logic [XLEN-1:0] mem_out_data,
  input  logic            mem_out_ready,
  input  logic            mem_addr_error,
  output lsu_state_t      dbg_state
);
  lsu_state_t      state_q;
  logic            store_q;
  logic [2:0]      funct3_q;
  logic [1:0]      lane_q;
  logic [XLEN-1:0] wdata_q;
  logic            resp_valid_q, resp_error_q;
  logic [XLEN-1:0] resp_data_q;
  logic            mem_in_valid_q, mem_out_valid_q;
  logic [XLEN-1:0] mem_in_addr_q, mem_in_data_q, mem_out_addr_q;

  logic [2:0]      al_funct3;
  logic [1:0]      al_lane;
  logic [XLEN-1:0] load_value, merged_word;
  logic            misaligned, illegal, reject;

  // In IDLE the checker looks at the live request; afterwards at the latched one.
  assign al_funct3 = (state_q == S_IDLE) ? req_funct3 : funct3_q;
  assign al_lane   = (state_q == S_IDLE) ? req_addr[1:0] : lane_q;
  assign reject    = illegal || misaligned || (req_store && req_funct3[2]);

  lsu_lane_align u_align (
    .funct3_i      (al_funct3),
    .addr_i        (al_lane),
    .mem_word_i    (mem_out_data),
    .wdata_i       (wdata_q),
    .load_value_o  (load_value),
    .merged_word_o (merged_word),
    .misaligned_o  (misaligned),
    .illegal_o     (illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      store_q         <= 1'b0;
      funct3_q        <= '0;
      lane_q          <= '0;
      wdata_q         <= '0;
      resp_valid_q    <= 1'b0;
      resp_error_q    <= 1'b0;
      resp_data_q     <= '0;
      mem_in_valid_q  <= 1'b0;
      mem_out_valid_q <= 1'b0;
      mem_in_addr_q   <= '0;
      mem_in_data_q   <= '0;
      mem_out_addr_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            store_q  <= req_store;
            funct3_q <= req_funct3;
            lane_q   <= req_addr[1:0];
            wdata_q  <= req_wdata;
            if (reject) begin
              resp_error_q <= 1'b1;
              resp_valid_q <= 1'b1;
              state_q      <= S_RESP;
            end else if (req_store && req_funct3 == F3_W) begin
              mem_in_valid_q <= 1'b1;
              mem_in_addr_q  <= word_addr(req_addr);
              mem_in_data_q  <= req_wdata;
              state_q        <= S_WRITE;
            end else begin
              mem_out_valid_q <= 1'b1;
              mem_out_addr_q  <= word_addr(req_addr);
              state_q         <= S_READ;
            end
          end
        end
        S_READ: begin
          if (mem_out_ready) begin
            mem_out_valid_q <= 1'b0;
            if (mem_addr_error) begin
              resp_error_q <= 1'b1;
              resp_valid_q <= 1'b1;
              state_q      <= S_RESP;
            end else if (store_q) begin
              mem_in_valid_q <= 1'b1;
              mem_in_addr_q  <= mem_out_addr_q;
              mem_in_data_q  <= merged_word;
              state_q        <= S_WRITE;
            end else begin
              resp_data_q  <= load_value;
              resp_valid_q <= 1'b1;
              state_q      <= S_RESP;
            end
          end
        end
        S_WRITE: begin
          if (mem_in_ready) begin
            mem_in_valid_q <= 1'b0;
            resp_error_q   <= mem_addr_error;
            resp_valid_q   <= 1'b1;
            state_q        <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_data_q  <= '0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign resp_valid    = resp_valid_q;
  assign resp_data     = resp_data_q;
  assign resp_error    = resp_error_q;
  assign mem_in_valid  = mem_in_valid_q;
  assign mem_in_addr   = mem_in_addr_q;
  assign mem_in_data   = mem_in_data_q;
  assign mem_out_valid = mem_out_valid_q;
  assign mem_out_addr  = mem_out_addr_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a word memory stand-in with random latency and a
// byte-addressed reference model of what each access should return.
module tb_load_store_unit;
  import felis_lsu_pkg::*;

  localparam logic [31:0] MEM_LIMIT = 32'h0028_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_error;
  logic [31:0] resp_data;
  logic [31:0] mem_in_addr, mem_in_data, mem_out_addr, mem_out_data;
  logic        mem_in_valid, mem_in_ready, mem_out_valid, mem_out_ready, mem_addr_error;
  lsu_state_t  dbg_state;

  load_store_unit dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_store      (req_store),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_data      (resp_data),
    .resp_error     (resp_error),
    .mem_in_addr    (mem_in_addr),
    .mem_in_data    (mem_in_data),
    .mem_in_valid   (mem_in_valid),
    .mem_in_ready   (mem_in_ready),
    .mem_out_addr   (mem_out_addr),
    .mem_out_valid  (mem_out_valid),
    .mem_out_data   (mem_out_data),
    .mem_out_ready  (mem_out_ready),
    .mem_addr_error (mem_addr_error),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters / check ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- memory stand-in ----------------
  logic [31:0] mem_words [int];
  bit          mem_stall = 1'b0;
  int          rd_hs = 0;
  int          wr_hs = 0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  initial begin
    mem_in_ready   = 1'b0;
    mem_out_ready  = 1'b0;
    mem_addr_error = 1'b0;
    mem_out_data   = '0;
    forever begin
      @(negedge clk);
      mem_in_ready   = 1'b0;
      mem_out_ready  = 1'b0;
      mem_addr_error = 1'b0;
      mem_out_data   = '0;
      if (!reset && !mem_stall && $urandom_range(0, 2) == 0) begin
        if (mem_out_valid) begin
          mem_out_ready = 1'b1;
          rd_hs++;
          if (mem_out_addr >= MEM_LIMIT) mem_addr_error = 1'b1;
          else if (mem_words.exists(int'(mem_out_addr >> 2))) mem_out_data = mem_words[int'(mem_out_addr >> 2)];
        end else if (mem_in_valid) begin
          mem_in_ready = 1'b1;
          wr_hs++;
          last_wr_addr = mem_in_addr;
          last_wr_data = mem_in_data;
          if (mem_in_addr >= MEM_LIMIT) mem_addr_error = 1'b1;
          else mem_words[int'(mem_in_addr >> 2)] = mem_in_data;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [int];

  function automatic logic [7:0] ref_byte(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic void ref_access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] wd, output logic [31:0] data,
                                     output bit err, output int n_rd, output int n_wr);
    int size = 0;
    bit uns = 1'b0;
    logic [31:0] v = '0;
    data = '0; err = 1'b0; n_rd = 0; n_wr = 0;
    case (f3)
      3'd0: size = 1;
      3'd1: size = 2;
      3'd2: size = 4;
      3'd4: begin size = 1; uns = 1'b1; end
      3'd5: begin size = 2; uns = 1'b1; end
      default: size = 0;
    endcase
    if (size == 0 || (st && f3[2]) || (int'(a) % size) != 0) begin
      err = 1'b1;
      return;
    end
    if (!st || size < 4) n_rd = 1;
    if (a >= MEM_LIMIT) begin
      err = 1'b1;
      if (st && size == 4) n_wr = 1;
      return;
    end
    if (st) begin
      n_wr = 1;
      for (int i = 0; i < size; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
    end else begin
      for (int i = 0; i < size; i++) v = v | (32'(ref_byte(int'(a) + i)) << (8 * i));
      if (!uns && size < 4 && v[8*size-1]) v = v | ~((32'h1 << (8 * size)) - 32'h1);
      data = v;
    end
  endfunction

  // ---------------- driver ----------------
  task automatic do_req(input string tag, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int hold,
                        output logic [31:0] got_d, output logic got_e);
    logic [31:0] exp_d;
    bit          exp_e;
    int          erd, ewr, rd0, wr0, lat;
    ref_access(st, f3, a, wd, exp_d, exp_e, erd, ewr);
    rd0 = rd_hs;
    wr0 = wr_hs;
    @(negedge clk);
    check({tag, " req_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_funct3 = 3'($urandom_range(0, 7));
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 300);
    check({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
    if (erd + ewr == 0) check({tag, " early_err_latency"}, 32'(lat), 32'd1);
    got_d = resp_data;
    got_e = resp_error;
    check({tag, " resp_data"}, resp_data, exp_d);
    check({tag, " resp_error"}, 32'(resp_error), 32'(exp_e));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold_valid"}, 32'(resp_valid), 32'd1);
      check({tag, " hold_data"}, resp_data, exp_d);
      check({tag, " hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    check({tag, " req_ready_back"}, 32'(req_ready), 32'd1);
    check({tag, " resp_valid_drop"}, 32'(resp_valid), 32'd0);
    check({tag, " reads"}, 32'(rd_hs - rd0), 32'(erd));
    check({tag, " writes"}, 32'(wr_hs - wr0), 32'(ewr));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] d;
    logic        e;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst resp_data", resp_data, 32'd0);
    check("rst resp_error", 32'(resp_error), 32'd0);
    check("rst mem_in_valid", 32'(mem_in_valid), 32'd0);
    check("rst mem_out_valid", 32'(mem_out_valid), 32'd0);
    check("rst mem_in_addr", mem_in_addr, 32'd0);
    check("rst mem_in_data", mem_in_data, 32'd0);
    check("rst mem_out_addr", mem_out_addr, 32'd0);
    check("rst state", 32'(dbg_state), 32'(S_IDLE));
    reset = 1'b0;

    // word round trip
    do_req("sw40", 1'b1, F3_W, 32'h40, 32'h1234_5678, 0, d, e);
    check("sw40 wr_addr", last_wr_addr, 32'h40);
    do_req("lw40", 1'b0, F3_W, 32'h40, 32'h0, 0, d, e);
    check("lw40 const", d, 32'h1234_5678);

    // byte store and loads
    do_req("sb41", 1'b1, F3_B, 32'h41, 32'hFFFF_FFAB, 0, d, e);
    check("sb41 merged", last_wr_data, 32'h1234_AB78);
    do_req("lb41", 1'b0, F3_B, 32'h41, 32'h0, 0, d, e);
    check("lb41 const", d, 32'hFFFF_FFAB);
    do_req("lbu41", 1'b0, F3_BU, 32'h41, 32'h0, 0, d, e);
    check("lbu41 const", d, 32'h0000_00AB);

    // half store and loads, with response backpressure
    do_req("sh42", 1'b1, F3_H, 32'h42, 32'h0000_8001, 0, d, e);
    check("sh42 merged", last_wr_data, 32'h8001_AB78);
    do_req("lh42", 1'b0, F3_H, 32'h42, 32'h0, 5, d, e);
    check("lh42 const", d, 32'hFFFF_8001);
    do_req("lhu42", 1'b0, F3_HU, 32'h42, 32'h0, 0, d, e);
    check("lhu42 const", d, 32'h0000_8001);

    // misalignment and illegal width: fault without memory traffic
    do_req("lw41_mis", 1'b0, F3_W, 32'h41, 32'h0, 0, d, e);
    check("lw41_mis err", 32'(e), 32'd1);
    do_req("sw42_mis", 1'b1, F3_W, 32'h42, 32'h5, 0, d, e);
    do_req("f3_011", 1'b0, 3'b011, 32'h40, 32'h0, 0, d, e);
    do_req("sbu_ill", 1'b1, F3_BU, 32'h40, 32'h7, 0, d, e);

    // range boundary
    do_req("lw_oor", 1'b0, F3_W, MEM_LIMIT, 32'h0, 0, d, e);
    check("lw_oor err", 32'(e), 32'd1);
    do_req("sb_oor", 1'b1, F3_B, MEM_LIMIT, 32'h11, 0, d, e);
    do_req("sw_oor", 1'b1, F3_W, MEM_LIMIT, 32'h22, 0, d, e);
    do_req("lw_last", 1'b0, F3_W, MEM_LIMIT - 32'd4, 32'h0, 0, d, e);
    check("lw_last err", 32'(e), 32'd0);

    // reset while a read is outstanding
    mem_stall = 1'b1;
    @(negedge clk);
    req_valid  = 1'b1;
    req_store  = 1'b0;
    req_funct3 = F3_W;
    req_addr   = 32'h44;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("mid_read out_valid", 32'(mem_out_valid), 32'd1);
    check("mid_read out_addr", mem_out_addr, 32'h44);
    check("mid_read state", 32'(dbg_state), 32'(S_READ));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst2 out_valid", 32'(mem_out_valid), 32'd0);
    check("rst2 out_addr", mem_out_addr, 32'd0);
    check("rst2 req_ready", 32'(req_ready), 32'd1);
    check("rst2 resp_valid", 32'(resp_valid), 32'd0);
    check("rst2 resp_data", resp_data, 32'd0);
    reset     = 1'b0;
    mem_stall = 1'b0;

    // random traffic
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      logic [2:0]  f3;
      bit          st;
      if ($urandom_range(0, 7) == 0) a = MEM_LIMIT - 32'd8 + 32'($urandom_range(0, 15));
      else a = 32'h40 + 32'($urandom_range(0, 63));
      f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7))
                                        : ($urandom_range(0, 1) ? 3'($urandom_range(0, 2))
                                                                : 3'($urandom_range(4, 5)));
      st = ($urandom_range(0, 2) == 0);
      if (f3 == F3_W || f3 == F3_H || f3 == F3_HU) begin
        if ($urandom_range(0, 5) != 0) a = (f3 == F3_W) ? {a[31:2], 2'b00} : {a[31:1], 1'b0};
      end
      do_req("rnd", st, f3, a, $urandom, $urandom_range(0, 2), d, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
